// File: rtl/cpu_pkg.sv
// Shared definitions for the register-select encoder: FSM states, IR field
// positions and the sign-extension helper for the C constant.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_DRIVE,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      SEL_RA,
      SEL_RB,
      SEL_RC
   } sel_t;

   typedef enum logic [1:0] {
      DIR_NONE,
      DIR_IN,
      DIR_OUT,
      DIR_BA
   } dir_t;

   localparam int IR_W    = 32;
   localparam int FIELD_W = 4;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;
   localparam int C_W     = 19;

   function automatic logic [IR_W-1:0] sign_ext_c(input logic [C_W-1:0] c);
      return {{(IR_W-C_W){c[C_W-1]}}, c};
   endfunction

endpackage

// File: rtl/decoder_4to16.sv
// Plain 4-to-16 one-hot decoder with an enable; all-zero when disabled.
module decoder_4to16
   import cpu_pkg::*;
(
   input  logic [FIELD_W-1:0] sel,
   input  logic               en,
   output logic [15:0]        onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/select_encode.sv
// Select-and-encode unit: holds the IR and turns gr*/direction strobes into a
// single one-cycle register enable (or the R0-reads-zero flag).
module select_encode
   import cpu_pkg::*;
(
   input  logic              clock,
   input  logic              clear,
   input  logic [IR_W-1:0]   bus_in,
   input  logic              ir_in,
   input  logic              gra,
   input  logic              grb,
   input  logic              grc,
   input  logic              r_in,
   input  logic              r_out,
   input  logic              ba_out,
   output logic [15:0]       r_in_en,
   output logic [15:0]       r_out_en,
   output logic              r0_zero,
   output logic [IR_W-1:0]   c_sign_extended,
   output logic              busy,
   output logic              done
);

   // Bits above Ra are opcode bits that nothing in this unit decodes, so only
   // the operand portion of the instruction word is held.
   logic [RA_MSB:0]    ir_q;
   state_t             state_q, state_d;
   sel_t               sel_q;
   dir_t               dir_q;
   logic [FIELD_W-1:0] field_q;
   logic               start;
   logic               drive_en;
   logic [15:0]        onehot;

   assign start = (gra | grb | grc) & (r_in | r_out | ba_out);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) ir_q <= '0;
      else if (ir_in) ir_q <= bus_in[RA_MSB:0];
   end

   // State register
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_DECODE;
         ST_DECODE: state_d = ST_DRIVE;
         ST_DRIVE:  state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Request capture on leaving IDLE, field capture on leaving DECODE
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         sel_q   <= SEL_RA;
         dir_q   <= DIR_NONE;
         field_q <= '0;
      end else begin
         if (state_q == ST_IDLE && start) begin
            if (gra)      sel_q <= SEL_RA;
            else if (grb) sel_q <= SEL_RB;
            else          sel_q <= SEL_RC;
            if (r_in)       dir_q <= DIR_IN;
            else if (r_out) dir_q <= DIR_OUT;
            else            dir_q <= DIR_BA;
         end
         if (state_q == ST_DECODE) begin
            case (sel_q)
               SEL_RA:  field_q <= ir_q[RA_MSB:RA_LSB];
               SEL_RB:  field_q <= ir_q[RB_MSB:RB_LSB];
               default: field_q <= ir_q[RC_MSB:RC_LSB];
            endcase
         end
      end
   end

   decoder_4to16 u_dec (
      .sel    (field_q),
      .en     (drive_en),
      .onehot (onehot)
   );

   // Output logic
   always_comb begin
      r0_zero  = 1'b0;
      drive_en = 1'b0;
      r_in_en  = '0;
      r_out_en = '0;
      if (state_q == ST_DRIVE) begin
         if (dir_q == DIR_BA && field_q == '0) r0_zero = 1'b1;
         else                                  drive_en = 1'b1;
         if (dir_q == DIR_IN) r_in_en  = onehot;
         else                 r_out_en = onehot;
      end
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_DONE);
   end

   assign c_sign_extended = sign_ext_c(ir_q[C_W-1:0]);

endmodule

// File: tb/tb_select_encode.sv
// Directed bench for select_encode: drives on falling edges, checks on the
// following falling edges against hand-computed values.
module tb_select_encode;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] bus_in;
   logic        ir_in, gra, grb, grc, r_in, r_out, ba_out;
   logic [15:0] r_in_en, r_out_en;
   logic        r0_zero, busy, done;
   logic [31:0] c_sign_extended;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   select_encode dut (
      .clock           (clock),
      .clear           (clear),
      .bus_in          (bus_in),
      .ir_in           (ir_in),
      .gra             (gra),
      .grb             (grb),
      .grc             (grc),
      .r_in            (r_in),
      .r_out           (r_out),
      .ba_out          (ba_out),
      .r_in_en         (r_in_en),
      .r_out_en        (r_out_en),
      .r0_zero         (r0_zero),
      .c_sign_extended (c_sign_extended),
      .busy            (busy),
      .done            (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_ir(input logic [31:0] v);
      bus_in = v;
      ir_in  = 1'b1;
      @(negedge clock);
      ir_in  = 1'b0;
   endtask

   task automatic drop_strobes();
      {gra, grb, grc}      = 3'b000;
      {r_in, r_out, ba_out} = 3'b000;
   endtask

   // gr = {gra,grb,grc}, dir = {r_in,r_out,ba_out}; called on a falling edge
   task automatic run_op(input string tag, input logic [2:0] gr, input logic [2:0] dir,
                         input logic [15:0] exp_in, input logic [15:0] exp_out,
                         input logic exp_r0);
      {gra, grb, grc}       = gr;
      {r_in, r_out, ba_out} = dir;
      @(negedge clock);
      drop_strobes();
      check({tag, "_decode_busy"}, 32'(busy), 32'd1);
      check({tag, "_decode_en"}, {r_in_en, r_out_en}, 32'd0);
      @(negedge clock);
      check({tag, "_drive_en"}, {r_in_en, r_out_en}, {exp_in, exp_out});
      check({tag, "_drive_r0"}, {31'd0, r0_zero}, {31'd0, exp_r0});
      check({tag, "_drive_done"}, 32'(done), 32'd0);
      @(negedge clock);
      check({tag, "_done_pulse"}, 32'(done), 32'd1);
      check({tag, "_done_en"}, {r_in_en, r_out_en}, 32'd0);
      @(negedge clock);
      check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      clear  = 1'b0;
      bus_in = '0;
      ir_in  = 1'b0;
      drop_strobes();
      #2;
      check("reset_en", {r_in_en, r_out_en}, 32'd0);
      check("reset_flags", {29'd0, r0_zero, busy, done}, 32'd0);
      check("reset_c", c_sign_extended, 32'd0);
      @(negedge clock);
      clear = 1'b1;

      load_ir(32'h0A98_0000);
      run_op("ra_rin", 3'b100, 3'b100, 16'h0020, 16'h0000, 1'b0);
      run_op("rb_rout", 3'b010, 3'b010, 16'h0000, 16'h0008, 1'b0);
      run_op("prio_gr", 3'b110, 3'b010, 16'h0000, 16'h0020, 1'b0);
      run_op("prio_dir", 3'b100, 3'b110, 16'h0020, 16'h0000, 1'b0);
      run_op("rc_rin", 3'b001, 3'b100, 16'h0001, 16'h0000, 1'b0);
      run_op("ra_ba", 3'b100, 3'b001, 16'h0000, 16'h0020, 1'b0);

      // strobe with no direction does nothing
      gra = 1'b1;
      @(negedge clock);
      check("noop_busy0", 32'(busy), 32'd0);
      gra = 1'b0;
      @(negedge clock);
      check("noop_busy1", {30'd0, busy, done}, 32'd0);

      load_ir(32'h0280_0000);
      run_op("ba_r0", 3'b010, 3'b001, 16'h0000, 16'h0000, 1'b1);
      load_ir(32'h0038_0000);
      run_op("ba_r7", 3'b010, 3'b001, 16'h0000, 16'h0080, 1'b0);

      load_ir(32'h0004_0000);
      check("c_neg", c_sign_extended, 32'hFFFC_0000);
      load_ir(32'h0003_FFFF);
      check("c_pos", c_sign_extended, 32'h0003_FFFF);

      // strobes and IR loads while busy
      load_ir(32'h0A98_0000);
      gra = 1'b1; r_in = 1'b1;
      @(negedge clock);
      drop_strobes();
      grb = 1'b1; r_out = 1'b1;
      bus_in = 32'h0B80_0000; ir_in = 1'b1;
      @(negedge clock);
      check("busy_drive_en", {r_in_en, r_out_en}, {16'h0020, 16'h0000});
      bus_in = 32'h0004_0000;
      @(negedge clock);
      check("busy_done", 32'(done), 32'd1);
      check("busy_done_en", {r_in_en, r_out_en}, 32'd0);
      drop_strobes();
      ir_in = 1'b0;
      @(negedge clock);
      check("busy_idle", {30'd0, busy, done}, 32'd0);
      check("busy_ir_loaded", c_sign_extended, 32'hFFFC_0000);
      @(negedge clock);
      check("busy_no_queue", {busy, done, r0_zero, 13'd0, r_in_en | r_out_en}, 32'd0);

      // asynchronous clear during DRIVE
      load_ir(32'h0A98_0000);
      gra = 1'b1; r_in = 1'b1;
      @(negedge clock);
      drop_strobes();
      @(negedge clock);
      check("rst_pre_en", 32'(r_in_en), 32'h0000_0020);
      #2 clear = 1'b0;
      #1;
      check("rst_async_en", {r_in_en, r_out_en}, 32'd0);
      check("rst_async_flags", {29'd0, r0_zero, busy, done}, 32'd0);
      check("rst_async_c", c_sign_extended, 32'd0);
      @(negedge clock);
      check("rst_held", {busy, done, r0_zero, 13'd0, r_in_en | r_out_en}, 32'd0);
      clear = 1'b1;
      run_op("post_rst", 3'b100, 3'b100, 16'h0001, 16'h0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/select_encode.md
SELECT_ENCODE -- requirements
Module: select_encode

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port bus_in, input, 32, the BusMuxOut value, sampled as instruction word.
REQ-004 SHALL have port ir_in, input, 1, loads the IR from bus_in.
REQ-005 SHALL have ports gra, grb, grc, input, 1 each, field-select strobes for Ra, Rb and Rc.
REQ-006 SHALL have ports r_in, r_out, ba_out, input, 1 each, the direction of the requested transfer.
REQ-007 SHALL have port r_in_en, output, 16, one-hot R0in..R15in enables.
REQ-008 SHALL have port r_out_en, output, 16, one-hot R0out..R15out enables for the bus encoder.
REQ-009 SHALL have port r0_zero, output, 1, asserted when ba_out has selected R0, so that the bus sees 0.
REQ-010 SHALL have port c_sign_extended, output, 32, C field for the bus C_out source.
REQ-011 SHALL have ports busy and done, output, 1 each; done is a one-cycle completion pulse.

Function
REQ-012 SHALL hold a 32-bit IR that loads bus_in on the edge where ir_in=1, and SHALL otherwise hold its value.
REQ-013 SHALL define the fields as Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15] and C=IR[18:0].
REQ-014 SHALL drive c_sign_extended = IR[18:0] sign-extended from bit 18, combinationally from the IR.
REQ-015 SHALL run FSM IDLE -> DECODE -> DRIVE -> DONE -> IDLE.
REQ-016 SHALL leave IDLE for DECODE only when a gr* strobe is present together with at least one of r_in, r_out or ba_out.
REQ-017 SHALL, in DECODE, register the selected 4-bit field and the direction.
REQ-018 SHALL resolve multiple gr* strobes with priority gra > grb > grc.
REQ-019 SHALL resolve multiple directions with priority r_in > r_out > ba_out.
REQ-020 SHALL, in DRIVE, assert exactly one bit of r_in_en (r_in) or of r_out_en (r_out or ba_out) for exactly one cycle.
REQ-021 SHALL keep all enables zero in every other state.
REQ-022 SHALL, in DRIVE when ba_out is selected and the field is 0, keep r_out_en=0 and assert r0_zero for that cycle.
REQ-023 SHALL pulse done for one cycle in DONE.
REQ-024 SHALL hold busy=1 in DECODE, DRIVE and DONE.
REQ-025 SHALL give a latency from the strobe edge to the enable of 2 cycles, and to done of 3 cycles.
REQ-026 SHALL ignore strobes while busy; no queuing.
REQ-027 SHALL use the IR value captured in DECODE, so that an ir_in during DRIVE or DONE does not alter the active enable.
REQ-028 SHALL let ir_in load the IR in any state.
REQ-029 SHALL treat a gr* strobe with no direction as a no-op: the FSM stays in IDLE.

Reset
REQ-030 SHALL, on clear=0, asynchronously force IR=0, FSM=IDLE, r_in_en=0, r_out_en=0, r0_zero=0, busy=0 and done=0; c_sign_extended then reads 0.
REQ-031 SHALL, on reset mid-operation, abort with no further enable pulse, and SHALL accept a new strobe in the first cycle after clear deasserts.

Structure
REQ-032 SHALL place the FSM state enum, the field bit positions and the C width (19) in shared package cpu_pkg.
REQ-033 SHALL instantiate one sub-module, decoder_4to16, used for both the r_in_en and r_out_en one-hot generation.

Verification
REQ-034 SHALL cover: ir_in with bus_in=0x0A980000 (Ra=5, Rb=3, Rc=0), then gra+r_in -> r_in_en=0x0020 for exactly one cycle at +2, done at +3.
REQ-035 SHALL cover: with the same IR, grb+r_out -> r_out_en=0x0008 for one cycle; gra+grb+r_out together -> r_out_en=0x0020 (priority).
REQ-036 SHALL cover: IR with Rb=0, then grb+ba_out -> r_out_en=0, r0_zero=1 for one cycle; the same with Rb=7 -> r_out_en=0x0080, r0_zero=0.
REQ-037 SHALL cover: IR[18:0]=0x40000 -> c_sign_extended=0xFFFC0000; IR[18:0]=0x3FFFF -> 0x0003FFFF.
REQ-038 SHALL cover: a second strobe while busy is ignored, with a single enable pulse only; an ir_in during DRIVE leaves the active enable unchanged.
REQ-039 SHALL cover: clear=0 asserted in DRIVE -> all outputs 0 immediately without a clock edge; a strobe on the first cycle after release is serviced normally.
